// File: rtl/mdu_pkg.sv
// Shared definitions for the multiply/divide unit.
// Holds the op encodings, the FSM state encoding and the default operand width.
package mdu_pkg;

  localparam int DEFAULT_WIDTH = 32;

  typedef enum logic [2:0] {
    OP_MULT  = 3'd0,
    OP_MULTU = 3'd1,
    OP_DIV   = 3'd2,
    OP_DIVU  = 3'd3,
    OP_MTHI  = 3'd4,
    OP_MTLO  = 3'd5,
    OP_RSV6  = 3'd6,
    OP_RSV7  = 3'd7
  } op_e;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_BUSY  = 2'd1,
    S_FIXUP = 2'd2,
    S_DONE  = 2'd3
  } state_e;

endpackage

// File: rtl/mult_div_unit_if.sv
// Request/result bundle between a pipeline front end and the multiply/divide unit.
// The master drives requests and operands; the slave (the unit) returns status and HI/LO.
interface mult_div_unit_if #(
  parameter int WIDTH = mdu_pkg::DEFAULT_WIDTH
) ();

  logic             start_i;
  logic [2:0]       op_i;
  logic [WIDTH-1:0] rs_data_i;
  logic [WIDTH-1:0] rt_data_i;
  logic             busy_o;
  logic             done_o;
  logic             div_by_zero_o;
  logic [WIDTH-1:0] hi_o;
  logic [WIDTH-1:0] lo_o;

  modport master (
    output start_i, op_i, rs_data_i, rt_data_i,
    input  busy_o, done_o, div_by_zero_o, hi_o, lo_o
  );

  modport slave (
    input  start_i, op_i, rs_data_i, rt_data_i,
    output busy_o, done_o, div_by_zero_o, hi_o, lo_o
  );

endinterface

// File: rtl/mdu_sign_fix.sv
// Conditional two's-complement negation: yields a magnitude from a signed value,
// or re-applies a sign to an unsigned result.
module mdu_sign_fix #(
  parameter int W = 32
) (
  input  logic [W-1:0] value_i,
  input  logic         negate_i,
  output logic [W-1:0] value_o
);

  assign value_o = negate_i ? (~value_i + W'(1)) : value_i;

endmodule

// File: rtl/mult_div_unit.sv
// Iterative multiply/divide unit with HI/LO result registers.
// One shift-add or restoring-subtract step per cycle on operand magnitudes, then a sign fixup.
module mult_div_unit
  import mdu_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  mult_div_unit_if.slave   bus
);

  localparam int CW = $clog2(WIDTH);

  state_e             state_q, state_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0]   opb_q, opb_d;
  logic               is_div_q, is_div_d;
  logic               neg_q_q, neg_q_d;
  logic               neg_r_q, neg_r_d;
  logic               dz_q, dz_d;
  logic [WIDTH-1:0]   hi_q, hi_d;
  logic [WIDTH-1:0]   lo_q, lo_d;

  op_e                op_in;
  logic               signed_op;
  logic               div_op;
  logic               rs_neg, rt_neg;
  logic [WIDTH-1:0]   mag_a, mag_b;
  logic [2*WIDTH-1:0] prod_fix;
  logic [WIDTH-1:0]   quot_fix, rem_fix;
  logic [WIDTH:0]     mul_sum;
  logic [WIDTH:0]     div_trial;

  assign op_in     = op_e'(bus.op_i);
  assign signed_op = (op_in == OP_MULT) || (op_in == OP_DIV);
  assign div_op    = (op_in == OP_DIV) || (op_in == OP_DIVU);
  assign rs_neg    = signed_op && bus.rs_data_i[WIDTH-1];
  assign rt_neg    = signed_op && bus.rt_data_i[WIDTH-1];

  mdu_sign_fix #(.W(WIDTH)) u_mag_a (
    .value_i(bus.rs_data_i), .negate_i(rs_neg), .value_o(mag_a));

  mdu_sign_fix #(.W(WIDTH)) u_mag_b (
    .value_i(bus.rt_data_i), .negate_i(rt_neg), .value_o(mag_b));

  mdu_sign_fix #(.W(2*WIDTH)) u_fix_prod (
    .value_i(acc_q), .negate_i(neg_q_q), .value_o(prod_fix));

  mdu_sign_fix #(.W(WIDTH)) u_fix_quot (
    .value_i(acc_q[WIDTH-1:0]), .negate_i(neg_q_q), .value_o(quot_fix));

  mdu_sign_fix #(.W(WIDTH)) u_fix_rem (
    .value_i(acc_q[2*WIDTH-1:WIDTH]), .negate_i(neg_r_q), .value_o(rem_fix));

  // Multiply keeps {partial, multiplier}; divide keeps {remainder, dividend->quotient}.
  assign mul_sum   = {1'b0, acc_q[2*WIDTH-1:WIDTH]} +
                     {1'b0, (acc_q[0] ? opb_q : {WIDTH{1'b0}})};
  assign div_trial = acc_q[2*WIDTH-1:WIDTH-1] - {1'b0, opb_q};

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    acc_d    = acc_q;
    opb_d    = opb_q;
    is_div_d = is_div_q;
    neg_q_d  = neg_q_q;
    neg_r_d  = neg_r_q;
    dz_d     = dz_q;
    hi_d     = hi_q;
    lo_d     = lo_q;

    case (state_q)
      S_IDLE: begin
        if (bus.start_i) begin
          if (!bus.op_i[2]) begin
            acc_d    = {{WIDTH{1'b0}}, mag_a};
            opb_d    = mag_b;
            is_div_d = div_op;
            dz_d     = div_op && (bus.rt_data_i == '0);
            // A zero divisor keeps LO all ones, so the quotient sign is never applied.
            neg_q_d  = (rs_neg ^ rt_neg) && !(div_op && (bus.rt_data_i == '0));
            neg_r_d  = div_op && rs_neg;
            cnt_d    = '0;
            state_d  = S_BUSY;
          end else if (op_in == OP_MTHI) begin
            hi_d = bus.rs_data_i;
          end else if (op_in == OP_MTLO) begin
            lo_d = bus.rs_data_i;
          end
        end
      end

      S_BUSY: begin
        if (is_div_q) begin
          acc_d = div_trial[WIDTH] ? {acc_q[2*WIDTH-2:0], 1'b0}
                                   : {div_trial[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};
        end else begin
          acc_d = {mul_sum, acc_q[WIDTH-1:1]};
        end
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == CW'(WIDTH-1)) begin
          cnt_d   = '0;
          state_d = S_FIXUP;
        end
      end

      S_FIXUP: begin
        if (is_div_q) begin
          hi_d = rem_fix;
          lo_d = quot_fix;
        end else begin
          {hi_d, lo_d} = prod_fix;
        end
        state_d = S_DONE;
      end

      S_DONE: state_d = S_IDLE;

      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      acc_q    <= '0;
      opb_q    <= '0;
      is_div_q <= 1'b0;
      neg_q_q  <= 1'b0;
      neg_r_q  <= 1'b0;
      dz_q     <= 1'b0;
      hi_q     <= '0;
      lo_q     <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      acc_q    <= acc_d;
      opb_q    <= opb_d;
      is_div_q <= is_div_d;
      neg_q_q  <= neg_q_d;
      neg_r_q  <= neg_r_d;
      dz_q     <= dz_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
    end
  end

  assign bus.busy_o        = (state_q != S_IDLE);
  assign bus.done_o        = (state_q == S_DONE);
  assign bus.div_by_zero_o = (state_q == S_DONE) && dz_q;
  assign bus.hi_o          = hi_q;
  assign bus.lo_o          = lo_q;

endmodule

// File: tb/tb_mult_div_unit.sv
// Directed self-checking bench for mult_div_unit.
// Each scenario task drives its own stimulus and compares against hand-computed results.
module tb_mult_div_unit;

  logic clk;
  logic reset;
  int   tests_run;
  int   tests_failed;

  mult_div_unit_if #(.WIDTH(32)) bus ();

  mult_div_unit #(.WIDTH(32)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Results captured by run_op for the most recent operation
  int          r_lat;
  int          r_busy;
  int          r_done;
  int          r_dz_cnt;
  logic [31:0] r_hi;
  logic [31:0] r_lo;
  logic        r_dz;

  // Launches one operation and watches 40 cycles; optionally injects a second start at cycle inj_k.
  task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                        input int inj_k, input logic [2:0] inj_op,
                        input logic [31:0] inj_a, input logic [31:0] inj_b);
    r_lat = 0; r_busy = 0; r_done = 0; r_dz_cnt = 0;
    r_hi = '0; r_lo = '0; r_dz = 1'b0;
    @(negedge clk);
    bus.start_i = 1'b1; bus.op_i = op; bus.rs_data_i = a; bus.rt_data_i = b;
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      if (k == 1) begin
        bus.start_i = 1'b0;
        bus.rs_data_i = 32'hDEADBEEF;
        bus.rt_data_i = 32'h0000_0000;
      end
      if (k == inj_k) begin
        bus.start_i = 1'b1; bus.op_i = inj_op; bus.rs_data_i = inj_a; bus.rt_data_i = inj_b;
      end
      if (k == inj_k + 1) bus.start_i = 1'b0;
      if (bus.busy_o) r_busy++;
      if (bus.div_by_zero_o) r_dz_cnt++;
      if (bus.done_o) begin
        r_done++;
        if (r_lat == 0) begin
          r_lat = k; r_hi = bus.hi_o; r_lo = bus.lo_o; r_dz = bus.div_by_zero_o;
        end
      end
    end
    bus.start_i = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    bus.start_i = 1'b1; bus.op_i = 3'd1; bus.rs_data_i = 32'd3; bus.rt_data_i = 32'd3;
    @(negedge clk);
    @(negedge clk);
    tests_run++;
    if (bus.busy_o !== 1'b0) begin tests_failed++; $display("[TB] FAIL reset_busy: got %b expected 0", bus.busy_o); end
    tests_run++;
    if (bus.done_o !== 1'b0) begin tests_failed++; $display("[TB] FAIL reset_done: got %b expected 0", bus.done_o); end
    tests_run++;
    if (bus.div_by_zero_o !== 1'b0) begin tests_failed++; $display("[TB] FAIL reset_dz: got %b expected 0", bus.div_by_zero_o); end
    tests_run++;
    if (bus.hi_o !== 32'h0) begin tests_failed++; $display("[TB] FAIL reset_hi: got %h expected 00000000", bus.hi_o); end
    tests_run++;
    if (bus.lo_o !== 32'h0) begin tests_failed++; $display("[TB] FAIL reset_lo: got %h expected 00000000", bus.lo_o); end
    bus.start_i = 1'b0;
    reset = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_multu();
    run_op(3'd1, 32'hFFFFFFFF, 32'hFFFFFFFF, 0, 3'd0, 32'h0, 32'h0);
    tests_run++;
    if (r_hi !== 32'hFFFFFFFE) begin tests_failed++; $display("[TB] FAIL multu_hi: got %h expected fffffffe", r_hi); end
    tests_run++;
    if (r_lo !== 32'h00000001) begin tests_failed++; $display("[TB] FAIL multu_lo: got %h expected 00000001", r_lo); end
    tests_run++;
    if (r_lat !== 34) begin tests_failed++; $display("[TB] FAIL multu_latency: got %0d expected 34", r_lat); end
    tests_run++;
    if (r_busy !== 34) begin tests_failed++; $display("[TB] FAIL multu_busy_cycles: got %0d expected 34", r_busy); end
    tests_run++;
    if (r_done !== 1) begin tests_failed++; $display("[TB] FAIL multu_done_count: got %0d expected 1", r_done); end
    tests_run++;
    if (r_dz_cnt !== 0) begin tests_failed++; $display("[TB] FAIL multu_dz_count: got %0d expected 0", r_dz_cnt); end
  endtask

  task automatic test_mult();
    run_op(3'd0, 32'hFFFFFFFD, 32'd5, 0, 3'd0, 32'h0, 32'h0);
    tests_run++;
    if (r_hi !== 32'hFFFFFFFF) begin tests_failed++; $display("[TB] FAIL mult_neg_hi: got %h expected ffffffff", r_hi); end
    tests_run++;
    if (r_lo !== 32'hFFFFFFF1) begin tests_failed++; $display("[TB] FAIL mult_neg_lo: got %h expected fffffff1", r_lo); end
    run_op(3'd0, 32'h80000000, 32'h80000000, 0, 3'd0, 32'h0, 32'h0);
    tests_run++;
    if (r_hi !== 32'h40000000) begin tests_failed++; $display("[TB] FAIL mult_min_hi: got %h expected 40000000", r_hi); end
    tests_run++;
    if (r_lo !== 32'h00000000) begin tests_failed++; $display("[TB] FAIL mult_min_lo: got %h expected 00000000", r_lo); end
    tests_run++;
    if (r_lat !== 34) begin tests_failed++; $display("[TB] FAIL mult_latency: got %0d expected 34", r_lat); end
  endtask

  task automatic test_div();
    run_op(3'd2, 32'hFFFFFFF9, 32'd2, 0, 3'd0, 32'h0, 32'h0);
    tests_run++;
    if (r_lo !== 32'hFFFFFFFD) begin tests_failed++; $display("[TB] FAIL div_neg_lo: got %h expected fffffffd", r_lo); end
    tests_run++;
    if (r_hi !== 32'hFFFFFFFF) begin tests_failed++; $display("[TB] FAIL div_neg_hi: got %h expected ffffffff", r_hi); end
    run_op(3'd3, 32'd7, 32'd2, 0, 3'd0, 32'h0, 32'h0);
    tests_run++;
    if (r_lo !== 32'd3) begin tests_failed++; $display("[TB] FAIL divu_lo: got %h expected 00000003", r_lo); end
    tests_run++;
    if (r_hi !== 32'd1) begin tests_failed++; $display("[TB] FAIL divu_hi: got %h expected 00000001", r_hi); end
    run_op(3'd2, 32'h80000000, 32'hFFFFFFFF, 0, 3'd0, 32'h0, 32'h0);
    tests_run++;
    if (r_lo !== 32'h80000000) begin tests_failed++; $display("[TB] FAIL div_ovf_lo: got %h expected 80000000", r_lo); end
    tests_run++;
    if (r_hi !== 32'h00000000) begin tests_failed++; $display("[TB] FAIL div_ovf_hi: got %h expected 00000000", r_hi); end
    tests_run++;
    if (r_dz_cnt !== 0) begin tests_failed++; $display("[TB] FAIL div_ovf_dz: got %0d expected 0", r_dz_cnt); end
  endtask

  task automatic test_div_zero();
    run_op(3'd3, 32'd5, 32'd0, 0, 3'd0, 32'h0, 32'h0);
    tests_run++;
    if (r_lo !== 32'hFFFFFFFF) begin tests_failed++; $display("[TB] FAIL divu0_lo: got %h expected ffffffff", r_lo); end
    tests_run++;
    if (r_hi !== 32'd5) begin tests_failed++; $display("[TB] FAIL divu0_hi: got %h expected 00000005", r_hi); end
    tests_run++;
    if (r_dz !== 1'b1) begin tests_failed++; $display("[TB] FAIL divu0_flag: got %b expected 1", r_dz); end
    tests_run++;
    if (r_dz_cnt !== 1) begin tests_failed++; $display("[TB] FAIL divu0_flag_cycles: got %0d expected 1", r_dz_cnt); end
    tests_run++;
    if (r_lat !== 34) begin tests_failed++; $display("[TB] FAIL divu0_latency: got %0d expected 34", r_lat); end
    run_op(3'd2, 32'hFFFFFFF9, 32'd0, 0, 3'd0, 32'h0, 32'h0);
    tests_run++;
    if (r_lo !== 32'hFFFFFFFF) begin tests_failed++; $display("[TB] FAIL div0_neg_lo: got %h expected ffffffff", r_lo); end
    tests_run++;
    if (r_hi !== 32'hFFFFFFF9) begin tests_failed++; $display("[TB] FAIL div0_neg_hi: got %h expected fffffff9", r_hi); end
  endtask

  task automatic test_back_to_back();
    run_op(3'd1, 32'd3, 32'd3, 5, 3'd1, 32'd2, 32'd2);
    tests_run++;
    if (r_lo !== 32'd9) begin tests_failed++; $display("[TB] FAIL ignored_start_lo: got %h expected 00000009", r_lo); end
    tests_run++;
    if (r_hi !== 32'd0) begin tests_failed++; $display("[TB] FAIL ignored_start_hi: got %h expected 00000000", r_hi); end
    tests_run++;
    if (r_done !== 1) begin tests_failed++; $display("[TB] FAIL ignored_start_done_count: got %0d expected 1", r_done); end
    tests_run++;
    if (r_lat !== 34) begin tests_failed++; $display("[TB] FAIL ignored_start_latency: got %0d expected 34", r_lat); end
  endtask

  task automatic test_reset_mid();
    int done_seen;
    done_seen = 0;
    @(negedge clk);
    bus.start_i = 1'b1; bus.op_i = 3'd1; bus.rs_data_i = 32'd6; bus.rt_data_i = 32'd7;
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      if (k == 1) bus.start_i = 1'b0;
      if (bus.done_o) done_seen++;
      if (k == 10) reset = 1'b1;
      if (k == 11) begin
        reset = 1'b0;
        tests_run++;
        if (bus.busy_o !== 1'b0) begin tests_failed++; $display("[TB] FAIL midreset_busy: got %b expected 0", bus.busy_o); end
        tests_run++;
        if (bus.hi_o !== 32'h0) begin tests_failed++; $display("[TB] FAIL midreset_hi: got %h expected 00000000", bus.hi_o); end
        tests_run++;
        if (bus.lo_o !== 32'h0) begin tests_failed++; $display("[TB] FAIL midreset_lo: got %h expected 00000000", bus.lo_o); end
      end
    end
    tests_run++;
    if (done_seen !== 0) begin tests_failed++; $display("[TB] FAIL midreset_done_count: got %0d expected 0", done_seen); end
  endtask

  task automatic test_move();
    int busy_seen;
    int done_seen;
    busy_seen = 0;
    done_seen = 0;
    @(negedge clk);
    bus.start_i = 1'b1; bus.op_i = 3'd4; bus.rs_data_i = 32'hCAFEF00D;
    @(negedge clk);
    bus.start_i = 1'b0;
    tests_run++;
    if (bus.hi_o !== 32'hCAFEF00D) begin tests_failed++; $display("[TB] FAIL mthi_hi: got %h expected cafef00d", bus.hi_o); end
    bus.start_i = 1'b1; bus.op_i = 3'd5; bus.rs_data_i = 32'h12345678;
    @(negedge clk);
    bus.start_i = 1'b0; bus.rs_data_i = 32'h0;
    tests_run++;
    if (bus.lo_o !== 32'h12345678) begin tests_failed++; $display("[TB] FAIL mtlo_lo: got %h expected 12345678", bus.lo_o); end
    tests_run++;
    if (bus.hi_o !== 32'hCAFEF00D) begin tests_failed++; $display("[TB] FAIL mtlo_hi_kept: got %h expected cafef00d", bus.hi_o); end
    bus.start_i = 1'b1; bus.op_i = 3'd6; bus.rs_data_i = 32'h55555555; bus.rt_data_i = 32'd1;
    for (int k = 0; k < 4; k++) begin
      if (bus.busy_o) busy_seen++;
      if (bus.done_o) done_seen++;
      @(negedge clk);
      bus.start_i = 1'b0;
    end
    tests_run++;
    if (busy_seen !== 0) begin tests_failed++; $display("[TB] FAIL move_busy_cycles: got %0d expected 0", busy_seen); end
    tests_run++;
    if (done_seen !== 0) begin tests_failed++; $display("[TB] FAIL move_done_cycles: got %0d expected 0", done_seen); end
    tests_run++;
    if (bus.lo_o !== 32'h12345678) begin tests_failed++; $display("[TB] FAIL reserved_lo_kept: got %h expected 12345678", bus.lo_o); end
  endtask

  initial begin
    tests_run = 0;
    tests_failed = 0;
    reset = 1'b1;
    bus.start_i = 1'b0;
    bus.op_i = 3'd0;
    bus.rs_data_i = '0;
    bus.rt_data_i = '0;
    test_reset();
    test_multu();
    test_mult();
    test_div();
    test_div_zero();
    test_back_to_back();
    test_reset_mid();
    test_move();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/mult_div_unit.md
MULT_DIV_UNIT -- requirements
Module: mult_div_unit

Interface
REQ-001 Parameter: WIDTH, 32, operand width; HI/LO are WIDTH bits each.
REQ-002 clk  in  1  single clock; all state updates on rising edge.
REQ-003 reset  in  1  synchronous, active-high reset.
REQ-004 start_i  in  1  request; sampled only in IDLE.
REQ-005 op_i  in  3  0=MULT, 1=MULTU, 2=DIV, 3=DIVU, 4=MTHI, 5=MTLO, 6/7 reserved.
REQ-006 rs_data_i  in  WIDTH  operand A / dividend / MTHI-MTLO source (register-file Read_Data_1).
REQ-007 rt_data_i  in  WIDTH  operand B / divisor (register-file Read_Data_2).
REQ-008 busy_o  out  1  high whenever state is not IDLE.
REQ-009 done_o  out  1  one-cycle pulse; HI/LO hold the new result in that cycle.
REQ-010 div_by_zero_o  out  1  pulses with done_o when a DIV/DIVU divisor was zero.
REQ-011 hi_o  out  WIDTH  HI register.
REQ-012 lo_o  out  WIDTH  LO register.

Function
REQ-013 FSM states SHALL be IDLE, BUSY, FIXUP, DONE.
REQ-014 IDLE, start_i=1, op 0-3: operands, op and signedness captured; next state BUSY.
REQ-015 IDLE, start_i=1, op 4/5: HI (op 4) or LO (op 5) <= rs_data_i at that edge; stays IDLE; no busy_o, no done_o.
REQ-016 IDLE, start_i=1, op 6/7: ignored; no state change.
REQ-017 start_i outside IDLE (BUSY, FIXUP, DONE) SHALL be ignored; captured operands held.
REQ-018 BUSY SHALL last exactly WIDTH cycles: one shift-add (multiply) or one restoring-subtract (divide) step per cycle on operand magnitudes; iteration counter 0..WIDTH-1.
REQ-019 FIXUP: one cycle for sign correction; next state DONE.
REQ-020 DONE: hi_o/lo_o updated, done_o=1 for exactly one cycle; next state IDLE.
REQ-021 Latency: start edge to done_o high = WIDTH+2 cycles (34 for WIDTH=32); start accepted again from the cycle after done_o.
REQ-022 MULT/MULTU: {HI,LO} = full 2*WIDTH product; MULT negates the 2*WIDTH magnitude product when operand signs differ.
REQ-023 DIVU: LO=quotient, HI=remainder, unsigned.
REQ-024 DIV: quotient truncated toward zero, sign = signA xor signB; remainder sign = dividend sign.
REQ-025 DIV 0x80000000 / 0xFFFFFFFF SHALL yield LO=0x80000000, HI=0; no flag.
REQ-026 Divisor zero (DIV or DIVU): full latency; LO=all ones, HI=captured rs_data unmodified; div_by_zero_o=1 with done_o.
REQ-027 HI/LO SHALL change only in DONE or on MTHI/MTLO acceptance.

Reset
REQ-028 reset=1 at a clock edge: state IDLE, counter 0, busy_o=0, done_o=0, div_by_zero_o=0, hi_o=0, lo_o=0.
REQ-029 reset mid-operation aborts it; no done_o is issued for the aborted operation.
REQ-030 reset takes priority over start_i in the same cycle.

Structure
REQ-031 Shared package mdu_pkg SHALL hold op encodings, FSM state encoding and default WIDTH.
REQ-032 One sub-module, mdu_sign_fix, SHALL provide magnitude extraction and conditional two's-complement negation, used on capture and in FIXUP.
REQ-033 Datapath: one 2*WIDTH accumulator/remainder-quotient register, one WIDTH operand register, counter of clog2(WIDTH) bits.

Verification
REQ-034 MULTU 0xFFFFFFFF x 0xFFFFFFFF -> HI=0xFFFFFFFE, LO=0x00000001, done_o exactly 34 cycles after start, busy_o high for 34 cycles.
REQ-035 MULT 0xFFFFFFFD (-3) x 5 -> HI=0xFFFFFFFF, LO=0xFFFFFFF1; MULT 0x80000000 x 0x80000000 -> HI=0x40000000, LO=0.
REQ-036 DIV 0xFFFFFFF9 (-7) / 2 -> LO=0xFFFFFFFD, HI=0xFFFFFFFF; DIVU 7 / 2 -> LO=3, HI=1; DIV 0x80000000 / 0xFFFFFFFF -> LO=0x80000000, HI=0.
REQ-037 DIVU 5 / 0 -> LO=0xFFFFFFFF, HI=5, div_by_zero_o=1 in the done_o cycle only.
REQ-038 Second start_i (MULTU 2x2) issued 5 cycles into a MULTU 3x3 -> result HI=0, LO=9, single done_o; reset asserted 10 cycles into another op -> busy_o=0, HI=LO=0 next cycle, no done_o.
REQ-039 MTLO with rs_data_i=0x12345678 -> lo_o=0x12345678 after one edge, hi_o unchanged, busy_o and done_o never asserted.
